// File: rtl/seq_detect_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_fsm
//  Description : Parametrised serial sequence detector. Tracks the length of
//                the longest suffix of accepted bits that is a proper prefix
//                of PATTERN (MSB received first), raises a Mealy match flag
//                on the completing bit and keeps a saturating match count.
//                The next-state table is built at elaboration from PATTERN
//                using KMP-style fallback, so a failed bit never throws away
//                a partial match that is still viable.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N        pattern length in bits (2..16)
//    PATTERN  pattern to detect, PATTERN[N-1] is the first bit received
//    OVERLAP  1: overlapping matches allowed, 0: restart empty after a hit
//    CNT_W    width of the saturating match counter
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    en         in   x is valid this cycle; FSM holds when low
//    x          in   serial data bit
//    clear      in   synchronous clear of state and counter (beats en)
//    z          out  match flag for the bit completing PATTERN
//    state      out  current matched-prefix length, 0..N-1
//    match_cnt  out  saturating count of matches
//  Build option
//    SEQ_DET_REG_OUT_EN  when defined, z is registered and appears one cycle
//                        after the completing bit; cleared by rst_n and clear.
// ============================================================================
module seq_detect_fsm #(
  parameter int             N       = 3,
  parameter logic [N-1:0]   PATTERN = N'(3'b101),
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  x,
  input  logic                  clear,
  output logic                  z,
  output logic [$clog2(N)-1:0]  state,
  output logic [CNT_W-1:0]      match_cnt
);

  localparam int c_sw = $clog2(N);
  // Table covers every encodable state; codes >= N are unreachable and map to 0.
  localparam int c_ns = 1 << c_sw;

  typedef logic [c_sw-1:0] state_t;

  // --------------------------------------------------------------------------
  // Next matched-prefix length after appending bit b to a history whose
  // longest prefix-suffix is s. The candidate string is PATTERN's first s bits
  // followed by b; the result is the longest suffix of it that is a proper
  // prefix of PATTERN. Ascending k so the last hit is the longest.
  // --------------------------------------------------------------------------
  function automatic int kmp_next(input int s, input bit b);
    int res;
    int p;
    bit ok;
    bit sb;
    res = 0;
    if (s < N) begin
      for (int k = 1; k <= N - 1; k++) begin
        if (k <= s + 1) begin
          ok = 1'b1;
          for (int i = 0; i < k; i++) begin
            p  = s + 1 - k + i;
            sb = (p < s) ? PATTERN[N-1-p] : b;
            if (sb != PATTERN[N-1-i]) ok = 1'b0;
          end
          if (ok) res = k;
        end
      end
    end
    return res;
  endfunction

  // State after a full match with overlap: feeding the completing bit from
  // state N-1 yields exactly the longest proper border of PATTERN.
  localparam int c_border = kmp_next(N - 1, PATTERN[0]);

  state_t w_nxt0 [c_ns];
  state_t w_nxt1 [c_ns];

  for (genvar s = 0; s < c_ns; s++) begin : g_tbl
    assign w_nxt0[s] = state_t'(kmp_next(s, 1'b0));
    assign w_nxt1[s] = state_t'(kmp_next(s, 1'b1));
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_hit;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and Mealy output
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit       = en & ~clear & (r_state == state_t'(N - 1)) & (x == PATTERN[0]);
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clear) begin
      w_state_nxt = '0;
      w_cnt_nxt   = '0;
    end else if (en) begin
      if (w_hit) begin
        w_state_nxt = OVERLAP ? state_t'(c_border) : '0;
        if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end else begin
        w_state_nxt = x ? w_nxt1[r_state] : w_nxt0[r_state];
      end
    end
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic r_z;

  // w_hit is already low while clear is high, so clear also zeroes r_z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z <= 1'b0;
    end else begin
      r_z <= w_hit;
    end
  end

  assign z = r_z;
`else
  assign z = w_hit;
`endif

  assign state     = r_state;
  assign match_cnt = r_cnt;

endmodule
`default_nettype wire
